// File: rtl/outpass4_frame_config_ser.sv
// Output pass BEL for the RAM_IO tile: per-bit combinational/registered pass,
// EN-gated capture, or a 4-bit LSB-first serializer with frame/last strobes.
module outpass4_frame_config_ser #(
  parameter int NoConfigBits = 6
) (
  input  logic                    UserCLK,
  input  logic                    UserRST,
  input  logic [3:0]              I,
  input  logic                    EN,
  output logic                    BUSY,
  output logic [3:0]              O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_GATED  = 2'b01;
  localparam logic [1:0] MODE_SERIAL = 2'b10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [1:0] mode;
  logic       serial;
  logic [3:0] q_q, q_d;
  logic [3:0] sr_q, sr_d;
  logic [1:0] cnt_q, cnt_d;
  logic [0:0] state_q, state_d;
  logic       shifting;
  logic       last_bit;
  logic [3:0] pass_o;

  assign mode   = ConfigBits[5:4];
  assign serial = (mode == MODE_SERIAL);

  always_comb begin
    q_d     = q_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (!serial) begin
      // Leaving SERIAL drops any partial frame.
      state_d = ST_IDLE;
      cnt_d   = 2'd0;
      if (mode == MODE_GATED) begin
        if (EN) q_d = I;
      end else begin
        q_d = I;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (EN) begin
            sr_d    = I;
            cnt_d   = 2'd0;
            state_d = ST_SHIFT;
          end
        end
        default: begin
          if (cnt_q == 2'd3) begin
            if (EN) begin
              sr_d  = I;
              cnt_d = 2'd0;
            end else begin
              sr_d    = sr_q >> 1;
              cnt_d   = 2'd0;
              state_d = ST_IDLE;
            end
          end else begin
            sr_d  = sr_q >> 1;
            cnt_d = cnt_q + 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      q_q     <= 4'd0;
      sr_q    <= 4'd0;
      cnt_q   <= 2'd0;
      state_q <= ST_IDLE;
    end else begin
      q_q     <= q_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign shifting = serial && (state_q == ST_SHIFT);
  assign last_bit = (cnt_q == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pass
      assign pass_o[gi] = ConfigBits[gi] ? q_q[gi] : I[gi];
    end
  endgenerate

  // Serial outputs depend only on registered state, never on I or EN.
  always_comb begin
    O = pass_o;
    if (serial) begin
      O = shifting ? {1'b0, last_bit, 1'b1, sr_q[0]} : 4'd0;
    end
  end

  assign BUSY = shifting && !last_bit;

endmodule

// File: tb/tb_outpass4_frame_config_ser.sv
// Bench for outpass4_frame_config_ser: directed vectors with literal expectations
// plus a per-cycle comparison against a cycle-scheduled behavioural model.
module tb_outpass4_frame_config_ser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_s = 4'd0;
  logic       en_s = 1'b0;
  logic [5:0] cfg = 6'd0;
  logic [5:0] cfg_nx = 6'd0;
  logic       busy;
  logic [3:0] o;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;
  int cyc = 0;

  // Model state: registered pass value and a per-cycle schedule of serial outputs.
  logic [3:0] q_m = 4'd0;
  logic [3:0] s_o [0:2047];
  bit         s_b [0:2047];

  outpass4_frame_config_ser #(.NoConfigBits(6)) dut (
    .UserCLK   (clk),
    .UserRST   (rst),
    .I         (i_s),
    .EN        (en_s),
    .BUSY      (busy),
    .O         (o),
    .ConfigBits(cfg)
  );

  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 2048; k++) begin
      s_o[k] = 4'd0;
      s_b[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      if (rst || cfg[5:4] != 2'b10) begin
        for (int j = 1; j <= 4; j++) begin
          s_o[cyc + j] = 4'd0;
          s_b[cyc + j] = 1'b0;
        end
      end
      if (rst) begin
        q_m = 4'd0;
      end else if (cfg[5:4] == 2'b01) begin
        if (en_s) q_m = i_s;
      end else if (cfg[5:4] != 2'b10) begin
        q_m = i_s;
      end else if (en_s && !s_b[cyc]) begin
        // Accepted word occupies the next four cycles, LSB first.
        for (int j = 1; j <= 4; j++) begin
          s_o[cyc + j] = {1'b0, (j == 4), 1'b1, i_s[j-1]};
          s_b[cyc + j] = (j < 4);
        end
      end
      cyc = cyc + 1;
    end
  end

  initial begin
    logic [3:0] eo;
    logic       eb;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        if (cfg[5:4] == 2'b10) begin
          eo = s_o[cyc];
          eb = s_b[cyc];
        end else begin
          for (int k = 0; k < 4; k++) eo[k] = cfg[k] ? q_m[k] : i_s[k];
          eb = 1'b0;
        end
        n_cmp++;
        if (o !== eo || busy !== eb) begin
          n_bad++;
          $display("FAIL model cyc=%0d: O=%h BUSY=%b, expected O=%h BUSY=%b", cyc, o, busy, eo, eb);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [3:0] iv, input logic ev);
    @(posedge clk);
    #1;
    rst  = r;
    cfg  = cfg_nx;
    i_s  = iv;
    en_s = ev;
    @(negedge clk);
  endtask

  task automatic dchk(input logic r, input logic [3:0] iv, input logic ev,
                      input logic [3:0] eo, input logic eb, input string nm);
    drive(r, iv, ev);
    n_cmp++;
    if (o !== eo || busy !== eb) begin
      n_bad++;
      $display("FAIL %s: O=%h BUSY=%b, expected O=%h BUSY=%b", nm, o, busy, eo, eb);
    end
    $display("txn %s: I=%h EN=%b RST=%b -> O=%h BUSY=%b", nm, iv, ev, r, o, busy);
  endtask

  initial begin
    // PASS, bits 0 and 2 registered
    cfg_nx = 6'b00_0101;
    drive(1'b1, 4'h0, 1'b0);
    drive(1'b1, 4'h0, 1'b0);
    cmp_en = 1'b1;
    dchk(1'b0, 4'hA, 1'b0, 4'hA, 1'b0, "pass_a");
    dchk(1'b0, 4'h5, 1'b0, 4'h0, 1'b0, "pass_5a");
    dchk(1'b0, 4'h5, 1'b0, 4'h5, 1'b0, "pass_5b");
    dchk(1'b1, 4'hF, 1'b0, 4'hF, 1'b0, "rst_edge");
    dchk(1'b1, 4'hF, 1'b0, 4'hA, 1'b0, "rst_regs0");
    dchk(1'b0, 4'hF, 1'b0, 4'hA, 1'b0, "rst_hold");
    dchk(1'b0, 4'hF, 1'b0, 4'hF, 1'b0, "pass_f");

    // GATED, all bits registered
    cfg_nx = 6'b01_1111;
    drive(1'b1, 4'h0, 1'b0);
    drive(1'b1, 4'h0, 1'b0);
    dchk(1'b0, 4'h3, 1'b1, 4'h0, 1'b0, "gate_cap");
    for (int k = 0; k < 5; k++) dchk(1'b0, 4'hC, 1'b0, 4'h3, 1'b0, "gate_hold");
    dchk(1'b0, 4'hC, 1'b1, 4'h3, 1'b0, "gate_en");
    dchk(1'b0, 4'h0, 1'b0, 4'hC, 1'b0, "gate_new");

    // SERIAL single frame, I=1011
    cfg_nx = 6'b10_0000;
    drive(1'b1, 4'h0, 1'b0);
    drive(1'b1, 4'h0, 1'b0);
    dchk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, "ser_idle");
    dchk(1'b0, 4'hB, 1'b1, 4'h0, 1'b0, "ser_t");
    dchk(1'b0, 4'h0, 1'b0, 4'h3, 1'b1, "ser_t1");
    dchk(1'b0, 4'h0, 1'b0, 4'h3, 1'b1, "ser_t2");
    dchk(1'b0, 4'h0, 1'b0, 4'h2, 1'b1, "ser_t3");
    dchk(1'b0, 4'h0, 1'b0, 4'h7, 1'b0, "ser_t4");
    dchk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, "ser_t5");

    // Back-to-back 9 then 6
    dchk(1'b0, 4'h9, 1'b1, 4'h0, 1'b0, "b2b_t");
    dchk(1'b0, 4'h0, 1'b0, 4'h3, 1'b1, "b2b_t1");
    dchk(1'b0, 4'h0, 1'b0, 4'h2, 1'b1, "b2b_t2");
    dchk(1'b0, 4'h0, 1'b0, 4'h2, 1'b1, "b2b_t3");
    dchk(1'b0, 4'h6, 1'b1, 4'h7, 1'b0, "b2b_t4");
    dchk(1'b0, 4'h0, 1'b0, 4'h2, 1'b1, "b2b_t5");
    dchk(1'b0, 4'h0, 1'b0, 4'h3, 1'b1, "b2b_t6");
    dchk(1'b0, 4'h0, 1'b0, 4'h3, 1'b1, "b2b_t7");
    dchk(1'b0, 4'h0, 1'b0, 4'h6, 1'b0, "b2b_t8");
    dchk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, "b2b_t9");

    // EN while busy is dropped
    dchk(1'b0, 4'hB, 1'b1, 4'h0, 1'b0, "ign_t");
    dchk(1'b0, 4'h0, 1'b0, 4'h3, 1'b1, "ign_t1");
    dchk(1'b0, 4'hF, 1'b1, 4'h3, 1'b1, "ign_t2");
    dchk(1'b0, 4'h0, 1'b0, 4'h2, 1'b1, "ign_t3");
    dchk(1'b0, 4'h0, 1'b0, 4'h7, 1'b0, "ign_t4");
    dchk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, "ign_t5");
    dchk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, "ign_t6");

    // Reset mid-frame, then a clean frame of 6
    dchk(1'b0, 4'hB, 1'b1, 4'h0, 1'b0, "rm_t");
    dchk(1'b0, 4'h0, 1'b0, 4'h3, 1'b1, "rm_t1");
    dchk(1'b1, 4'h0, 1'b0, 4'h3, 1'b1, "rm_t2");
    dchk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, "rm_t3");
    dchk(1'b0, 4'h6, 1'b1, 4'h0, 1'b0, "rm_new");
    dchk(1'b0, 4'h0, 1'b0, 4'h2, 1'b1, "rm_n1");
    dchk(1'b0, 4'h0, 1'b0, 4'h3, 1'b1, "rm_n2");
    dchk(1'b0, 4'h0, 1'b0, 4'h3, 1'b1, "rm_n3");
    dchk(1'b0, 4'h0, 1'b0, 4'h6, 1'b0, "rm_n4");
    dchk(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, "rm_n5");

    // Reserved mode behaves as PASS
    cfg_nx = 6'b11_0011;
    drive(1'b1, 4'h0, 1'b0);
    drive(1'b1, 4'h0, 1'b0);
    dchk(1'b0, 4'h6, 1'b0, 4'h4, 1'b0, "rsv_a");
    dchk(1'b0, 4'h9, 1'b0, 4'hA, 1'b0, "rsv_b");

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
